// File: rtl/pow3_sched.sv
// ---------------------------------------------------------------------------
// pow3_sched
//   Two requesters share a single AW x 2AW multiplier. Each served request
//   returns a^3 of the captured operand. An operation runs through four
//   states: capture in IDLE, square in SQ, cube in CU, and announce in DONE.
//   This gives one result every 4 cycles.
//
// Ports
//   clk      in   1    rising-edge clock
//   rst      in   1    asynchronous, active-high reset
//   req      in   2    per-requester request (bit i = requester i)
//   a0, a1   in   AW   unsigned operands of requester 0 / 1
//   gnt      out  2    one-hot grant pulse during SQ (operand was captured)
//   busy     out  1    high while the FSM is not IDLE
//   done     out  1    one-cycle result-valid pulse (DONE state)
//   done_id  out  1    requester whose result is on c
//   c        out  CW   a^3 of the served requester, CW = 3*AW
// ---------------------------------------------------------------------------
module pow3_sched #(
  parameter  int AW = 4,
  localparam int CW = 3 * AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [AW-1:0] a0,
  input  logic [AW-1:0] a1,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          done,
  output logic          done_id,
  output logic [CW-1:0] c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQ   = 2'd1,
    S_CU   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [AW-1:0]   r_a;        // captured operand (a_q)
  logic            r_id;       // captured requester index (id_q)
  logic            r_last;     // most recent winner, used to break ties
  logic [2*AW-1:0] r_y;        // a_q^2
  logic [CW-1:0]   r_c;
  logic            r_done_id;

  logic            w_any;
  logic            w_win_id;
  logic [2*AW-1:0] w_mul_b;
  logic [CW-1:0]   w_prod;

  // The product of a 2AW-bit and an AW-bit value fits exactly in CW bits.
  // Dropping the upper bits is therefore lossless here.
  function automatic logic [CW-1:0] trunc_cw(input logic [CW-1:0] x);
    return x;
  endfunction

  // Arbitration: a lone request wins outright. On a tie, the requester that
  // was not served last wins, which alternates the two requesters fairly.
  assign w_any = |req;

  always_comb begin
    w_win_id = 1'b0;
    case (req)
      2'b01:   w_win_id = 1'b0;
      2'b10:   w_win_id = 1'b1;
      2'b11:   w_win_id = ~r_last;
      default: w_win_id = 1'b0;
    endcase
  end

  // Shared multiplier. In SQ it forms a_q*a_q. In CU it forms y*a_q.
  assign w_mul_b = (r_state == S_CU) ? r_y : {{AW{1'b0}}, r_a};
  assign w_prod  = CW'(w_mul_b) * CW'(r_a);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_any ? S_SQ : S_IDLE;
      S_SQ:    w_next = S_CU;
      S_CU:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture and datapath registers.
  // Requests and operands are only sampled in IDLE. Input changes while busy
  // therefore cannot disturb the operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_id      <= 1'b0;
      r_last    <= 1'b1;   // requester 0 wins the first tie after reset
      r_y       <= '0;
      r_c       <= '0;
      r_done_id <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a    <= w_win_id ? a1 : a0;
            r_id   <= w_win_id;
            r_last <= w_win_id;
          end
        end
        S_SQ: begin
          r_y <= w_prod[2*AW-1:0];
        end
        S_CU: begin
          r_c       <= trunc_cw(w_prod);
          r_done_id <= r_id;   // valid during DONE, held until the next one
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode registered state only. There is no path from req.
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign gnt     = (r_state == S_SQ) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
  assign done_id = r_done_id;
  assign c       = r_c;

endmodule

// File: tb/tb_pow3_sched.sv
// ---------------------------------------------------------------------------
// tb_pow3_sched
//   Directed bench for pow3_sched (AW=4). Inputs change 1 time unit after
//   each rising edge, and outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_pow3_sched;

  localparam int AW = 4;
  localparam int CW = 3 * AW;

  logic          clk;
  logic          rst;
  logic [1:0]    req;
  logic [AW-1:0] a0;
  logic [AW-1:0] a1;
  logic [1:0]    gnt;
  logic          busy;
  logic          done;
  logic          done_id;
  logic [CW-1:0] c;

  int total;
  int fails;

  pow3_sched #(.AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a0      (a0),
    .a1      (a1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .c       (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst   = 1'b0;
    req   = 2'b00;
    a0    = '0;
    a1    = '0;

    // ---- reset state ----
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt",     32'(gnt),     32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_c",       32'(c),       32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // ---- tie out of reset: a0=3 first, then a1=5 four cycles later ----
    req = 2'b11; a0 = 4'd3; a1 = 4'd5;
    step();                                   // SQ
    chk("tie_gnt0",  32'(gnt),  32'b01);
    chk("tie_busy0", 32'(busy), 32'd1);
    req = 2'b10;
    step();                                   // CU
    a0 = 4'd9;                                // must not affect result
    chk("tie_cu_gnt", 32'(gnt), 32'd0);
    step();                                   // DONE
    chk("tie_done0", 32'(done),    32'd1);
    chk("tie_c0",    32'(c),       32'd27);
    chk("tie_id0",   32'(done_id), 32'd0);
    step();                                   // IDLE
    chk("tie_idle_done", 32'(done), 32'd0);
    step();                                   // SQ for requester 1
    chk("tie_gnt1", 32'(gnt), 32'b10);
    req = 2'b00;
    step();
    step();                                   // DONE
    chk("tie_done1", 32'(done),    32'd1);
    chk("tie_c1",    32'(c),       32'd125);
    chk("tie_id1",   32'(done_id), 32'd1);
    step();                                   // IDLE

    // ---- req=11 held for 8 operations: strict alternation, period 4 ----
    req = 2'b11; a0 = 4'd2; a1 = 4'd3;
    for (int k = 0; k < 8; k++) begin
      step();                                 // SQ
      chk("alt_gnt",     32'(gnt),  (k % 2 == 0) ? 32'b01 : 32'b10);
      chk("alt_sq_done", 32'(done), 32'd0);
      step();                                 // CU
      chk("alt_cu_done", 32'(done), 32'd0);
      step();                                 // DONE
      chk("alt_done",    32'(done),    32'd1);
      chk("alt_id",      32'(done_id), 32'(k % 2));
      chk("alt_c",       32'(c),       (k % 2 == 0) ? 32'd8 : 32'd27);
      step();                                 // IDLE
      chk("alt_idle_busy", 32'(busy), 32'd0);
    end
    req = 2'b00;
    step();

    // ---- single requester 0, a0=2 ----
    req = 2'b01; a0 = 4'd2;
    step();
    chk("r0_gnt", 32'(gnt), 32'b01);
    req = 2'b00;
    step();
    chk("r0_cu_gnt",  32'(gnt),  32'd0);
    chk("r0_cu_done", 32'(done), 32'd0);
    step();
    chk("r0_done", 32'(done),    32'd1);
    chk("r0_c",    32'(c),       32'd8);
    chk("r0_id",   32'(done_id), 32'd0);
    step();
    chk("r0_after_done", 32'(done), 32'd0);
    chk("r0_c_hold",     32'(c),    32'd8);

    // ---- zero operand: c=0, busy for exactly 3 cycles ----
    req = 2'b01; a0 = 4'd0;
    step();
    chk("z_busy_sq", 32'(busy), 32'd1);
    req = 2'b00;
    step();
    chk("z_busy_cu", 32'(busy), 32'd1);
    step();
    chk("z_busy_dn", 32'(busy), 32'd1);
    chk("z_done",    32'(done), 32'd1);
    chk("z_c",       32'(c),    32'd0);
    step();
    chk("z_busy_idle", 32'(busy), 32'd0);

    // ---- single requester 1, a1=15 (full-scale) ----
    req = 2'b10; a1 = 4'd15;
    step();
    chk("r1_gnt", 32'(gnt), 32'b10);
    req = 2'b00;
    step();
    step();
    chk("r1_done", 32'(done),    32'd1);
    chk("r1_c",    32'(c),       32'd3375);
    chk("r1_id",   32'(done_id), 32'd1);
    step();

    // ---- asynchronous reset while in CU ----
    req = 2'b01; a0 = 4'd7;
    step();                                   // SQ
    req = 2'b00;
    step();                                   // CU
    chk("ab_busy_cu", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ab_c",    32'(c),       32'd0);
    chk("ab_busy", 32'(busy),    32'd0);
    chk("ab_done", 32'(done),    32'd0);
    chk("ab_id",   32'(done_id), 32'd0);
    chk("ab_gnt",  32'(gnt),     32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ab_no_done", 32'(done), 32'd0);
      chk("ab_no_busy", 32'(busy), 32'd0);
    end
    req = 2'b10; a1 = 4'd1;
    step();
    chk("ab_gnt1", 32'(gnt), 32'b10);
    req = 2'b00;
    step();
    step();
    chk("ab_done1", 32'(done),    32'd1);
    chk("ab_c1",    32'(c),       32'd1);
    chk("ab_id1",   32'(done_id), 32'd1);
    step();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
